// File: rtl/hp_video_source.sv
// rtl/hp_video_source.sv - synthetic raster video source with H/V timing, test patterns and frame counter
module hp_video_source #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [1:0] PATTERN,
    input  logic [9:0] LEVEL,
    output logic       O_HS,
    output logic       O_VS,
    output logic [9:0] VIDEO,
    output logic       O_VISIBLE,
    output logic [7:0] FRAME
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = ($clog2(H_TOTAL + 1) > 10) ? $clog2(H_TOTAL + 1) : 10;
    localparam int VW = ($clog2(V_TOTAL + 1) > 10) ? $clog2(V_TOTAL + 1) : 10;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [7:0]    frame_q, frame_d;
    logic [1:0]    pat_q, pat_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          vis_q, vis_d;
    logic [9:0]    video_q, video_d;

    logic          h_end, v_end, active, hs_act, vs_act;
    logic [9:0]    pix;

    always_comb begin
        h_end   = (h_q == H_LAST);
        v_end   = (v_q == V_LAST);
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        pat_d   = pat_q;
        if (ENABLE) begin
            h_d = h_end ? '0 : h_q + HW'(1);
            if (h_end) begin
                v_d = v_end ? '0 : v_q + VW'(1);
                // End of frame: wrap, count the frame and pick up the next pattern together
                if (v_end) begin
                    frame_d = frame_q + 8'd1;
                    pat_d   = PATTERN;
                end
            end
        end

        active = (h_q < H_ACT_END) && (v_q < V_ACT_END);
        hs_act = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
        vs_act = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);

        case (pat_q)
            2'd0:    pix = LEVEL;
            2'd1:    pix = h_q[9:0];
            2'd2:    pix = (h_q[3] ^ v_q[3]) ? 10'h3FF : 10'h000;
            default: pix = (h_q[9:4] == frame_q[5:0]) ? 10'h3FF : 10'h000;
        endcase

        hs_d    = hs_act ? HS_POL : ~HS_POL;
        vs_d    = vs_act ? VS_POL : ~VS_POL;
        vis_d   = active;
        video_d = active ? pix : 10'h000;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
            pat_q   <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            vis_q   <= 1'b0;
            video_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            pat_q   <= pat_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            vis_q   <= vis_d;
            video_q <= video_d;
        end
    end

    assign O_HS      = hs_q;
    assign O_VS      = vs_q;
    assign VIDEO     = video_q;
    assign O_VISIBLE = vis_q;
    assign FRAME     = frame_q;

endmodule

// File: tb/tb_hp_video_source.sv
// tb/tb_hp_video_source.sv - directed bench for hp_video_source on a reduced 144x22 raster
module tb_hp_video_source;

    // Reduced raster: H 128+4+8+4 = 144, V 16+2+2+2 = 22, frame = 3168 clocks
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [1:0] pattern;
    logic [9:0] level;
    logic       hs0, vs0, vis0, hs1, vs1, vis1;
    logic [9:0] video0, video1;
    logic [7:0] frame0, frame1;

    int cyc;
    int errors;
    int checks;

    hp_video_source #(
        .H_ACTIVE(128), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut0 (
        .CLK(clk), .RESET(rst_n), .ENABLE(enable), .PATTERN(pattern), .LEVEL(level),
        .O_HS(hs0), .O_VS(vs0), .VIDEO(video0), .O_VISIBLE(vis0), .FRAME(frame0)
    );

    hp_video_source #(
        .H_ACTIVE(128), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut1 (
        .CLK(clk), .RESET(rst_n), .ENABLE(enable), .PATTERN(pattern), .LEVEL(level),
        .O_HS(hs1), .O_VS(vs1), .VIDEO(video1), .O_VISIBLE(vis1), .FRAME(frame1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (video0 !== 10'd0) begin errors++; $display("FAIL rst_video: got %0h expected 0", video0); end
        checks++; if (vis0 !== 1'b0) begin errors++; $display("FAIL rst_visible: got %0b expected 0", vis0); end
        checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL rst_hs_pol0: got %0b expected 1", hs0); end
        checks++; if (vs0 !== 1'b1) begin errors++; $display("FAIL rst_vs_pol0: got %0b expected 1", vs0); end
        checks++; if (frame0 !== 8'd0) begin errors++; $display("FAIL rst_frame: got %0d expected 0", frame0); end
        checks++; if (hs1 !== 1'b0) begin errors++; $display("FAIL rst_hs_pol1: got %0b expected 0", hs1); end
        checks++; if (vs1 !== 1'b0) begin errors++; $display("FAIL rst_vs_pol1: got %0b expected 0", vs1); end
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // First two lines after reset release; pat_q is 0 so VIDEO carries LEVEL
    task automatic test_line(input logic [9:0] exp_level);
        int vis_cnt = 0;
        int hs_low = 0;
        int hs_fall1 = -1;
        int hs_fall2 = -1;
        int hs1_rise = -1;
        logic hs_prev = 1'b1;
        logic hs1_prev = 1'b0;
        for (int k = 1; k <= 288; k++) begin
            step();
            if (k == 1) begin
                checks++; if (vis0 !== 1'b1) begin errors++; $display("FAIL first_visible: got %0b expected 1", vis0); end
                checks++; if (video0 !== exp_level) begin errors++; $display("FAIL first_video: got %0h expected %0h", video0, exp_level); end
                checks++; if (hs0 !== 1'b1 || vs0 !== 1'b1) begin errors++; $display("FAIL first_syncs: got hs=%0b vs=%0b expected 1 1", hs0, vs0); end
            end
            if (k == 128) begin
                checks++; if (video0 !== exp_level) begin errors++; $display("FAIL last_active_video: got %0h expected %0h", video0, exp_level); end
            end
            if (k == 129) begin
                checks++; if (vis0 !== 1'b0 || video0 !== 10'd0) begin errors++; $display("FAIL blank_start: got vis=%0b video=%0h expected 0 0", vis0, video0); end
            end
            if (k <= 144) begin
                vis_cnt += int'(vis0);
                hs_low  += int'(!hs0);
            end
            if (hs_prev && !hs0) begin
                if (hs_fall1 < 0) hs_fall1 = k;
                else if (hs_fall2 < 0) hs_fall2 = k;
            end
            if (!hs1_prev && hs1 && hs1_rise < 0) hs1_rise = k;
            hs_prev  = hs0;
            hs1_prev = hs1;
        end
        checks++; if (vis_cnt != 128) begin errors++; $display("FAIL visible_per_line: got %0d expected 128", vis_cnt); end
        checks++; if (hs_low != 8) begin errors++; $display("FAIL hs_width: got %0d expected 8", hs_low); end
        checks++; if (hs_fall1 != 133) begin errors++; $display("FAIL hs_start: got %0d expected 133", hs_fall1); end
        checks++; if (hs_fall2 != 277) begin errors++; $display("FAIL hs_period: got %0d expected 277", hs_fall2); end
        checks++; if (hs1_rise != 133) begin errors++; $display("FAIL hs_start_pol1: got %0d expected 133", hs1_rise); end
    endtask

    task automatic test_frames();
        int vs_fall1 = -1;
        int vs_fall2 = -1;
        int vs_low0 = 0;
        int vis1_cnt = 0;
        int blank_vis = 0;
        int y;
        logic vs_prev = 1'b1;
        while (cyc < 6336) begin
            step();
            y = ((cyc - 1) / 144) % 22;
            if (cyc <= 3168 && !vs0) vs_low0++;
            if (vs_prev && !vs0) begin
                if (vs_fall1 < 0) vs_fall1 = cyc;
                else if (vs_fall2 < 0) vs_fall2 = cyc;
            end
            vs_prev = vs0;
            if (cyc > 3168) vis1_cnt += int'(vis0);
            if (y >= 16 && vis0) blank_vis++;
            if (cyc == 3167) begin
                checks++; if (frame0 !== 8'd0) begin errors++; $display("FAIL frame_before_wrap: got %0d expected 0", frame0); end
            end
            if (cyc == 3168) begin
                checks++; if (frame0 !== 8'd1) begin errors++; $display("FAIL frame_at_wrap: got %0d expected 1", frame0); end
            end
            if (cyc == 3179) begin
                checks++; if (video0 !== 10'd10) begin errors++; $display("FAIL ramp_x10: got %0d expected 10", video0); end
            end
            if (cyc == 3989) begin
                checks++; if (video0 !== 10'd100) begin errors++; $display("FAIL ramp_x100: got %0d expected 100", video0); end
            end
        end
        checks++; if (frame0 !== 8'd2) begin errors++; $display("FAIL frame_two: got %0d expected 2", frame0); end
        checks++; if (vs_fall1 != 2593) begin errors++; $display("FAIL vs_start: got %0d expected 2593", vs_fall1); end
        checks++; if (vs_fall2 != 5761) begin errors++; $display("FAIL vs_period: got %0d expected 5761", vs_fall2); end
        checks++; if (vs_low0 != 288) begin errors++; $display("FAIL vs_width: got %0d expected 288", vs_low0); end
        checks++; if (vis1_cnt != 2048) begin errors++; $display("FAIL visible_per_frame: got %0d expected 2048", vis1_cnt); end
        checks++; if (blank_vis != 0) begin errors++; $display("FAIL visible_in_vblank: got %0d expected 0", blank_vis); end
    endtask

    task automatic test_pattern_switch();
        int pf, x, y;
        int mism_pre = 0;
        int mism_post = 0;
        int bright_post = 0;
        int mism_flat = 0;
        int act_flat = 0;
        logic [9:0] exp;
        pattern = 2'd2;
        while (cyc < 9504) step();
        while (cyc < 12672) begin
            step();
            pf = cyc - 9505;
            x = pf % 144;
            y = pf / 144;
            if (x < 128 && y < 16) exp = ((((x / 8) + (y / 8)) % 2) == 1) ? 10'h3FF : 10'h000;
            else exp = 10'h000;
            if (video0 !== exp) begin
                if (pf < 1440) mism_pre++;
                else mism_post++;
            end
            if (pf >= 1440 && video0 === 10'h3FF) bright_post++;
            if (cyc == 10944) begin
                pattern = 2'd0;
                level = 10'h155;
            end
        end
        checks++; if (mism_pre != 0) begin errors++; $display("FAIL checker_pre_switch: got %0d bad pixels expected 0", mism_pre); end
        checks++; if (mism_post != 0) begin errors++; $display("FAIL checker_post_switch: got %0d bad pixels expected 0", mism_post); end
        checks++; if (bright_post != 384) begin errors++; $display("FAIL checker_bright_count: got %0d expected 384", bright_post); end
        pattern = 2'd3;
        while (cyc < 15840) begin
            step();
            pf = cyc - 12673;
            x = pf % 144;
            y = pf / 144;
            exp = (x < 128 && y < 16) ? 10'h155 : 10'h000;
            if (video0 !== exp) mism_flat++;
            if (vis0) act_flat++;
        end
        checks++; if (mism_flat != 0) begin errors++; $display("FAIL flat_field: got %0d bad pixels expected 0", mism_flat); end
        checks++; if (act_flat != 2048) begin errors++; $display("FAIL flat_active_count: got %0d expected 2048", act_flat); end
    endtask

    task automatic test_moving_bar();
        int s, pf, x, y, mism, bright;
        logic [9:0] exp;
        for (int f = 5; f <= 7; f++) begin
            if (f == 7) pattern = 2'd1;
            s = f * 3168;
            mism = 0;
            bright = 0;
            while (cyc < s + 3168) begin
                step();
                pf = cyc - s - 1;
                x = pf % 144;
                y = pf / 144;
                exp = (x < 128 && y < 16 && x >= 16 * f && x < 16 * f + 16) ? 10'h3FF : 10'h000;
                if (video0 !== exp) mism++;
                if (video0 === 10'h3FF) bright++;
                if (pf == 100) begin
                    checks++; if (frame0 !== 8'(f)) begin errors++; $display("FAIL bar_frame_count: got %0d expected %0d", frame0, f); end
                end
            end
            checks++; if (mism != 0) begin errors++; $display("FAIL bar_pixels f%0d: got %0d bad pixels expected 0", f, mism); end
            checks++; if (bright != 256) begin errors++; $display("FAIL bar_size f%0d: got %0d expected 256", f, bright); end
        end
    endtask

    task automatic test_enable();
        logic [9:0] snap_video;
        logic [7:0] snap_frame;
        logic snap_hs, snap_vs, snap_vis;
        logic vs_prev;
        int changes = 0;
        int vs_fall = -1;
        while (cyc < 25344 + 771) step();
        checks++; if (video0 !== 10'd50) begin errors++; $display("FAIL pre_pause_pixel: got %0d expected 50", video0); end
        enable = 1'b0;
        snap_video = '0; snap_frame = '0; snap_hs = 1'b0; snap_vs = 1'b0; snap_vis = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (i == 0) begin
                checks++; if (video0 !== 10'd51) begin errors++; $display("FAIL pause_pixel: got %0d expected 51", video0); end
                snap_video = video0; snap_frame = frame0; snap_hs = hs0; snap_vs = vs0; snap_vis = vis0;
            end else if (video0 !== snap_video || frame0 !== snap_frame || hs0 !== snap_hs ||
                         vs0 !== snap_vs || vis0 !== snap_vis) begin
                changes++;
            end
        end
        checks++; if (changes != 0) begin errors++; $display("FAIL pause_static: got %0d changes expected 0", changes); end
        enable = 1'b1;
        step();
        checks++; if (video0 !== 10'd51) begin errors++; $display("FAIL resume_pixel: got %0d expected 51", video0); end
        step();
        checks++; if (video0 !== 10'd52) begin errors++; $display("FAIL resume_next: got %0d expected 52", video0); end
        vs_prev = vs0;
        while (cyc < 29512) begin
            step();
            if (vs_prev && !vs0 && vs_fall < 0) vs_fall = cyc;
            vs_prev = vs0;
            if (cyc == 29511) begin
                checks++; if (frame0 !== 8'd8) begin errors++; $display("FAIL stretched_frame_hold: got %0d expected 8", frame0); end
            end
        end
        checks++; if (frame0 !== 8'd9) begin errors++; $display("FAIL stretched_frame_wrap: got %0d expected 9", frame0); end
        checks++; if (vs_fall != 28937) begin errors++; $display("FAIL stretched_vs_start: got %0d expected 28937", vs_fall); end
    endtask

    task automatic test_reset_mid();
        while (cyc < 32259) step();
        checks++; if (vs1 !== 1'b1) begin errors++; $display("FAIL vsync_before_reset: got %0b expected 1", vs1); end
        rst_n = 1'b0;
        #1;
        checks++; if (vs1 !== 1'b0 || hs1 !== 1'b0) begin errors++; $display("FAIL async_sync_pol1: got hs=%0b vs=%0b expected 0 0", hs1, vs1); end
        checks++; if (vs0 !== 1'b1 || hs0 !== 1'b1) begin errors++; $display("FAIL async_sync_pol0: got hs=%0b vs=%0b expected 1 1", hs0, vs0); end
        checks++; if (video0 !== 10'd0 || vis0 !== 1'b0) begin errors++; $display("FAIL async_video: got video=%0h vis=%0b expected 0 0", video0, vis0); end
        checks++; if (frame0 !== 8'd0 || frame1 !== 8'd0) begin errors++; $display("FAIL async_frame: got %0d/%0d expected 0/0", frame0, frame1); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        test_line(10'h155);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        enable  = 1'b1;
        pattern = 2'd1;
        level   = 10'h2AB;
        test_reset();
        test_line(10'h2AB);
        test_frames();
        test_pattern_switch();
        test_moving_bar();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
